// File: rtl/unpadder1x.sv
// -----------------------------------------------------------------------------
// unpadder1x
//
// Strips the padding from one 576-bit (72-byte) padded block and returns the
// left-aligned message of up to 64 bytes. A valid block ends in END_BYTE at
// byte 71, then zero or more 8'h00 bytes, then DS_BYTE at byte n. Bytes
// 0..n-1 are the message. The block is scanned backwards one byte per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in         padded block, byte k = in[575-8k -: 8]
//   in_valid   block offered (sampled only in IDLE)
//   in_ready   high in IDLE; block accepted when in_valid & in_ready
//   out        recovered message, byte k = out[511-8k -: 8], zero-filled
//   byte_cnt   message length in bytes, 0..64
//   byte_num   length code: 0 = 0 B, 1 = 32 B, 2 = 64 B, 3 = other/error
//   err        malformed padding, qualified by out_valid
//   out_valid  result available (state OUT)
//   out_ready  consumer takes result when out_valid & out_ready
// -----------------------------------------------------------------------------
module unpadder1x #(
   parameter logic [7:0] DS_BYTE  = 8'h06,
   parameter logic [7:0] END_BYTE = 8'h80
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [575:0] in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [511:0] out,
   output logic [6:0]   byte_cnt,
   output logic [1:0]   byte_num,
   output logic         err,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {IDLE, TAIL, SCAN, OUT} state_t;

   state_t         state;
   logic [575:0]   buffer;
   logic [6:0]     index;
   logic           err_pend;   // byte 71 was bad; resolved on the next cycle

   logic [9:0]     bit_ofs;
   logic [575:0]   shifted;
   logic [7:0]     cur_byte;
   logic [511:0]   keep_mask;
   logic [511:0]   good_out;
   logic [1:0]     good_num;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);

   // Byte at the scan index, brought to the top of the buffer by a shift.
   assign bit_ofs  = {index, 3'b000};
   assign shifted  = buffer << bit_ofs;
   assign cur_byte = shifted[575:568];

   // Keep the first index bytes of the message area, zero the rest.
   // A shift of 512 yields zero, so index 64 keeps every byte.
   assign keep_mask = ~({512{1'b1}} >> bit_ofs);
   assign good_out  = buffer[575:64] & keep_mask;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      good_num = 2'd3;
      case (index)
         7'd0:    good_num = 2'd0;
         7'd32:   good_num = 2'd1;
         7'd64:   good_num = 2'd2;
         default: good_num = 2'd3;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the block buffer is plain flops, not a RAM, so clearing it
         // on reset is legal and keeps stale message data from lingering.
         state    <= IDLE;
         buffer   <= '0;
         index    <= '0;
         err_pend <= 1'b0;
         out      <= '0;
         byte_cnt <= '0;
         byte_num <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  buffer <= in;
                  state  <= TAIL;
               end
            end

            TAIL: begin
               // A bad end byte is held one extra cycle in err_pend so the
               // error result arrives two edges after accept.
               err_pend <= (buffer[7:0] != END_BYTE);
               index    <= 7'd70;
               state    <= SCAN;
            end

            SCAN: begin
               if (err_pend) begin
                  state <= OUT;
                  out      <= '0;
                  byte_cnt <= '0;
                  byte_num <= 2'd3;
                  err      <= 1'b1;
               end else if (cur_byte == 8'h00 && index != 7'd0) begin
                  index <= index - 7'd1;
               end else if (cur_byte == DS_BYTE && index <= 7'd64) begin
                  state    <= OUT;
                  out      <= good_out;
                  byte_cnt <= index;
                  byte_num <= good_num;
                  err      <= 1'b0;
               end else begin
                  // Zero at byte 0, stray byte, or message longer than 64 B.
                  state    <= OUT;
                  out      <= '0;
                  byte_cnt <= '0;
                  byte_num <= 2'd3;
                  err      <= 1'b1;
               end
            end

            OUT: begin
               err_pend <= 1'b0;
               if (out_ready) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unpadder1x.sv
// -----------------------------------------------------------------------------
// tb_unpadder1x : self-checking bench for unpadder1x.
// Directed blocks plus randomized blocks, all compared with a byte-level
// reference model that derives result and latency from the padding rules.
// -----------------------------------------------------------------------------
module tb_unpadder1x;

   logic         clk = 1'b0;
   logic         reset;
   logic [575:0] blk_in;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] dut_out;
   logic [6:0]   byte_cnt;
   logic [1:0]   byte_num;
   logic         err;
   logic         out_valid;
   logic         out_ready;

   int total = 0;
   int bad   = 0;
   int last_lat;

   always #5 clk = ~clk;

   unpadder1x dut (
      .clk       (clk),
      .reset     (reset),
      .in        (blk_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (dut_out),
      .byte_cnt  (byte_cnt),
      .byte_num  (byte_num),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: works on the 72 bytes directly.
   function automatic void model(input logic [575:0] blk, output logic [511:0] e_out,
                                 output int e_cnt, output int e_num, output logic e_err,
                                 output int e_lat);
      logic [7:0] b [72];
      int n;
      for (int k = 0; k < 72; k++) b[k] = blk[575 - 8*k -: 8];
      e_out = '0; e_cnt = 0; e_num = 3; e_err = 1'b1;
      if (b[71] != 8'h80) begin
         e_lat = 2;
         return;
      end
      n = 70;
      while (n > 0 && b[n] == 8'h00) n--;
      e_lat = 72 - n;
      if (b[n] == 8'h06 && n <= 64) begin
         e_err = 1'b0;
         e_cnt = n;
         for (int k = 0; k < n; k++) e_out[511 - 8*k -: 8] = b[k];
         e_num = (n == 0) ? 0 : (n == 32) ? 1 : (n == 64) ? 2 : 3;
      end
   endfunction

   task automatic run_block(input logic [575:0] blk, input int hold, input bit poke);
      logic [511:0] e_out, snap;
      int e_cnt, e_num, e_lat, lat;
      logic e_err;
      bit seen;
      model(blk, e_out, e_cnt, e_num, e_err, e_lat);
      @(negedge clk);
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      check("in_ready_idle", in_ready, 1'b1);
      blk_in   = blk;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      blk_in   = {18{$urandom}};   // must not be sampled after accept
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (poke) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            blk_in    = {18{$urandom}};
         end
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("out_valid_timeout", seen, 1'b1);
      last_lat = lat;
      check("latency", lat, e_lat);
      check("out", dut_out, e_out);
      check("byte_cnt", byte_cnt, e_cnt);
      check("byte_num", byte_num, e_num);
      check("err", err, e_err);
      check("in_ready_busy", in_ready, 1'b0);
      snap = dut_out;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1'b1);
         check("hold_out", dut_out, snap);
         check("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", out_valid, 1'b0);
      check("release_in_ready", in_ready, 1'b1);
   endtask

   function automatic logic [575:0] rand_block();
      logic [575:0] blk;
      int n, k, mode;
      blk  = '0;
      n    = $urandom_range(0, 70);
      mode = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) blk[575 - 8*i -: 8] = 8'($urandom);
      blk[575 - 8*n -: 8] = 8'h06;
      blk[7:0] = 8'h80;
      if (mode == 0) blk[7:0] = 8'($urandom);
      else if (mode == 1 && n < 70) begin
         k = $urandom_range(n + 1, 70);
         blk[575 - 8*k -: 8] = 8'($urandom_range(1, 255));
      end else if (mode == 2) blk[575 - 8*n -: 8] = 8'($urandom);
      return blk;
   endfunction

   logic [575:0] d_blk;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      blk_in    = '0;
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out", dut_out, '0);
      check("rst_byte_cnt", byte_cnt, 7'd0);
      check("rst_byte_num", byte_num, 2'd0);
      check("rst_err", err, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // 64-byte message
      run_block({{16{32'h90ABCDEF}}, 8'h06, 48'h0, 8'h80}, 0, 0);
      check("lat64", last_lat, 8);
      check("out64_const", dut_out, {16{32'h90ABCDEF}});
      // 32-byte message
      run_block({{8{32'h90ABCDEF}}, 8'h06, 304'h0, 8'h80}, 0, 0);
      check("lat32", last_lat, 40);
      // empty message
      run_block({8'h06, 560'h0, 8'h80}, 0, 0);
      check("lat0", last_lat, 72);
      // bad end byte
      run_block({{16{32'h90ABCDEF}}, 8'h06, 48'h0, 8'h81}, 0, 0);
      check("lat_bad_end", last_lat, 2);
      check("err_bad_end", err, 1'b1);
      // stray byte at 69
      run_block({{16{32'h90ABCDEF}}, 8'h06, 32'h0, 8'h55, 8'h00, 8'h80}, 0, 0);
      check("err_stray", err, 1'b1);
      // all zero before the end byte
      run_block({568'h0, 8'h80}, 0, 0);
      check("lat_all_zero", last_lat, 72);
      // 71-byte message reported as error
      run_block({{16{32'h90ABCDEF}}, 56'h11223344556677, 8'h86}, 0, 0);
      check("err_86", err, 1'b1);
      // DS beyond byte 64
      d_blk = {{16{32'h90ABCDEF}}, 16'h0102, 8'h06, 24'h0, 8'h80};
      run_block(d_blk, 0, 0);
      check("err_long", err, 1'b1);
      // back-pressure with in_valid / out_ready pokes during scan
      run_block({{16{32'h90ABCDEF}}, 8'h06, 48'h0, 8'h80}, 10, 1);

      // reset in the middle of a scan
      @(negedge clk);
      blk_in   = {{8{32'h90ABCDEF}}, 8'h06, 304'h0, 8'h80};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      begin
         bit rose = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) rose = 1'b1;
         end
         check("mid_rst_no_output", rose, 1'b0);
      end
      run_block({{8{32'h90ABCDEF}}, 8'h06, 304'h0, 8'h80}, 2, 0);
      check("post_rst_lat", last_lat, 40);

      // randomized blocks
      for (int t = 0; t < 60; t++)
         run_block(rand_block(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
